alu_seq_regfile: RTL

- Parametrised, handshaked successor to the team's 4-bit ALU with scratch memory.
- Accepts one operation per transaction on a valid/ready input channel and computes ADD, SUB, SHL, SHR, AND, XOR or a multi-cycle MUL.
- Presents the registered result and flags on a valid/ready output channel.
- Optionally writes the result into an internal DEPTH-entry register file; a combinational read port exposes any entry.

---
 rtl/alu_seq_regfile_if.sv | 35 +++
 rtl/alu_seq_regfile.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_regfile_if.sv
// Request/response channel of alu_seq_regfile: operand request, registered result
// with flags, and the register-file read port.
interface alu_seq_regfile_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [2:0]        opcode;
  logic              write_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  result;
  logic              carry;
  logic              zero_flag;
  logic              neg_flag;
  logic              ovf_flag;
  logic [WIDTH-1:0]  mem_out;

  modport master (
    output in_valid, a, b, opcode, write_en, wr_addr, rd_addr, out_ready,
    input  in_ready, out_valid, result, carry, zero_flag, neg_flag, ovf_flag, mem_out
  );

  modport slave (
    input  in_valid, a, b, opcode, write_en, wr_addr, rd_addr, out_ready,
    output in_ready, out_valid, result, carry, zero_flag, neg_flag, ovf_flag, mem_out
  );
endinterface

// File: rtl/alu_seq_regfile.sv
// Handshaked ALU with shift-add multiplier and DEPTH-entry result register file.
// Define ALU_SEQ_MAC_EN to turn opcode 111 into multiply-accumulate.
module alu_seq_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_seq_regfile_if.slave bus
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_MAC = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             z;
    logic             n;
    logic             v;
  } alu_t;

  state_t              state_q, state_d;
  alu_t                out_q, alu_out, mul_out;
  logic [2*WIDTH-1:0]  acc_q, mcand_q, acc_step;
  logic [WIDTH-1:0]    mplier_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic                in_ready, accept, is_multi, op_rsvd, last_cyc, wr_fire;
  logic [ADDR_W-1:0]   wr_addr_sel;
  logic [WIDTH-1:0]    wr_data;
`ifdef ALU_SEQ_MAC_EN
  logic [2:0]          op_q;
  logic [WIDTH-1:0]    macc_q;
  logic [WIDTH:0]      mac_sum;
`endif

  // Single-cycle ops; shifts use a double-width vector so the last bit out lands at a fixed index
  function automatic alu_t alu_single(input logic [2:0] op,
                                      input logic [WIDTH-1:0] x,
                                      input logic [WIDTH-1:0] y);
    alu_t               r;
    logic [WIDTH:0]     s;
    logic [2*WIDTH-1:0] e;
    r = '0;
    s = '0;
    e = '0;
    case (op)
      OP_ADD: begin
        s     = {1'b0, x} + {1'b0, y};
        r.res = s[WIDTH-1:0];
        r.c   = s[WIDTH];
        r.v   = (x[WIDTH-1] == y[WIDTH-1]) && (r.res[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        r.res = x - y;
        r.c   = (x < y);
        r.n   = (x < y) && r.res[WIDTH-1];
        r.v   = (x[WIDTH-1] != y[WIDTH-1]) && (r.res[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SHL: begin
        e     = {{WIDTH{1'b0}}, x} << y;
        r.res = e[WIDTH-1:0];
        r.c   = e[WIDTH];
      end
      OP_SHR: begin
        e     = {x, {WIDTH{1'b0}}} >> y;
        r.res = e[2*WIDTH-1:WIDTH];
        r.c   = e[WIDTH-1];
      end
      OP_AND:  r.res = x & y;
      OP_XOR:  r.res = x ^ y;
      default: r = '0;
    endcase
    r.z = (op <= OP_XOR) && (r.res == '0);
    return r;
  endfunction

  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = bus.in_valid && in_ready;
  assign alu_out  = alu_single(bus.opcode, bus.a, bus.b);

`ifdef ALU_SEQ_MAC_EN
  assign is_multi = (bus.opcode == OP_MUL) || (bus.opcode == OP_MAC);
  assign op_rsvd  = 1'b0;
  assign last_cyc = (state_q == EXEC) &&
                    (cnt_q == ((op_q == OP_MAC) ? CNT_W'(WIDTH) : CNT_W'(WIDTH - 1)));
`else
  assign is_multi = (bus.opcode == OP_MUL);
  assign op_rsvd  = (bus.opcode == OP_MAC);
  assign last_cyc = (state_q == EXEC) && (cnt_q == CNT_W'(WIDTH - 1));
`endif

  // Multiplier step and final result; MAC spends one extra cycle adding the old entry
  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    mul_out  = '0;
`ifdef ALU_SEQ_MAC_EN
    mac_sum  = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, macc_q};
    if (op_q == OP_MAC) begin
      mul_out.res = mac_sum[WIDTH-1:0];
      mul_out.c   = (|acc_q[2*WIDTH-1:WIDTH]) | mac_sum[WIDTH];
    end else begin
      mul_out.res = acc_step[WIDTH-1:0];
      mul_out.c   = |acc_step[2*WIDTH-1:WIDTH];
    end
`else
    mul_out.res = acc_step[WIDTH-1:0];
    mul_out.c   = |acc_step[2*WIDTH-1:WIDTH];
`endif
    mul_out.z = (mul_out.res == '0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = is_multi ? EXEC : DONE;
      EXEC:    if (last_cyc) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign wr_fire     = (accept && !is_multi && !op_rsvd && bus.write_en) || (last_cyc && we_q);
  assign wr_addr_sel = accept ? bus.wr_addr : waddr_q;
  assign wr_data     = accept ? alu_out.res : mul_out.res;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (accept) begin
        we_q     <= bus.write_en;
        waddr_q  <= bus.wr_addr;
        mcand_q  <= {{WIDTH{1'b0}}, bus.a};
        mplier_q <= bus.b;
        acc_q    <= '0;
        cnt_q    <= '0;
`ifdef ALU_SEQ_MAC_EN
        op_q     <= bus.opcode;
        macc_q   <= mem_q[bus.wr_addr];
`endif
        if (!is_multi) out_q <= alu_out;
      end else if (state_q == EXEC) begin
        acc_q    <= acc_step;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
        if (last_cyc) out_q <= mul_out;
      end
      if (wr_fire) mem_q[wr_addr_sel] <= wr_data;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = out_q.res;
  assign bus.carry     = out_q.c;
  assign bus.zero_flag = out_q.z;
  assign bus.neg_flag  = out_q.n;
  assign bus.ovf_flag  = out_q.v;
  assign bus.mem_out   = mem_q[bus.rd_addr];
endmodule
